// File: rtl/difftest_csr_snapshot_queue.sv
// Difftest CSR snapshot collector: samples a vector of CSRs on enable, queues
// snapshots in a small FIFO and drains each one as a header + register frame
// over a valid/ready word stream. With DELTA_MODE set, only registers that
// changed since the last queued snapshot are carried in the frame.
module difftest_csr_snapshot_queue #(
  parameter int NUM_REGS   = 18,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 4,
  parameter int DELTA_MODE = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_REGS*DATA_W-1:0]   io_regs,
  input  logic [7:0]                   io_coreid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [5:0]                   out_index,
  output logic                         out_last,
  output logic [15:0]                  drop_count,
  output logic [$clog2(DEPTH):0]       fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = NUM_REGS * DATA_W;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  // Snapshot storage, one slot per FIFO entry
  logic [RW-1:0]       mem_regs [DEPTH];
  logic [7:0]          mem_core [DEPTH];
  logic [15:0]         mem_seq  [DEPTH];
  logic [NUM_REGS-1:0] mem_mask [DEPTH];

  state_t              state, state_nx;
  logic [5:0]          idx, idx_nx;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [15:0]         seq;
  logic [RW-1:0]       baseline;
  logic                base_valid;

  logic [NUM_REGS-1:0] cap_mask;
  logic                fifo_full;
  logic                do_push, do_drop, do_pop;

  logic [RW-1:0]       head_regs;
  logic [7:0]          head_core;
  logic [15:0]         head_seq;
  logic [NUM_REGS-1:0] head_mask;
  logic [39:0]         hdr_mask;
  logic [5:0]          first_idx, next_idx;
  logic                has_next;

  assign head_regs = mem_regs[rd_ptr];
  assign head_core = mem_core[rd_ptr];
  assign head_seq  = mem_seq[rd_ptr];
  assign head_mask = mem_mask[rd_ptr];

  // Capture mask: all registers, or only those differing from the baseline
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cap_mask = '1;
    if (DELTA_MODE != 0 && base_valid) begin
      for (int i = 0; i < NUM_REGS; i++)
        cap_mask[i] = io_regs[i*DATA_W +: DATA_W] != baseline[i*DATA_W +: DATA_W];
    end
  end

  // Occupancy sampled at the start of the cycle decides drop vs enqueue; no bypass
  assign fifo_full = (fifo_count == FULL_COUNT);
  assign do_push   = enable && (cap_mask != '0) && !fifo_full;
  assign do_drop   = enable && (cap_mask != '0) && fifo_full;

  // Header mask field is zero-extended to 40 bits
  always_comb begin
    hdr_mask = '0;
    hdr_mask[NUM_REGS-1:0] = head_mask;
  end

  // Locate the lowest set mask bit and the next set bit above the current index
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (head_mask[i]) first_idx = 6'(i);
      if (head_mask[i] && (6'(i) > idx)) begin
        next_idx = 6'(i);
        has_next = 1'b1;
      end
    end
  end

  // Serializer next-state and stream outputs
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    do_pop    = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0) state_nx = S_HDR;
      end
      S_HDR: begin
        out_valid      = 1'b1;
        out_data[63:0] = {head_core, head_seq, hdr_mask};
        out_index      = 6'h3F;
        if (out_ready) begin
          state_nx = S_DATA;
          idx_nx   = first_idx;
        end
      end
      S_DATA: begin
        out_valid = 1'b1;
        out_data  = head_regs[int'(idx)*DATA_W +: DATA_W];
        out_index = idx;
        out_last  = !has_next;
        if (out_ready) begin
          if (has_next) begin
            idx_nx = next_idx;
          end else begin
            do_pop   = 1'b1;
            state_nx = (fifo_count > CW'(1)) ? S_HDR : S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Serializer state, FIFO pointers, sequence, baseline and drop counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      seq        <= '0;
      baseline   <= '0;
      base_valid <= 1'b0;
      drop_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      idx   <= idx_nx;
      if (do_push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        seq        <= seq + 16'd1;
        baseline   <= io_regs;
        base_valid <= 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (do_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  // Snapshot payload write
  always_ff @(posedge clock) begin
    // NOTE: payload storage is not reset; the pointers and count guarantee stale slots are never read.
    if (do_push) begin
      mem_regs[wr_ptr] <= io_regs;
      mem_core[wr_ptr] <= io_coreid;
      mem_seq[wr_ptr]  <= seq;
      mem_mask[wr_ptr] <= cap_mask;
    end
  end

endmodule
